// File: rtl/traffic_signal_monitor.sv
// Receive-side checker for the controller lamp bus: decodes the phase, checks lamp heads
// for illegal codes, conflicts, short clearance and stuck outputs, and latches a fault.
module traffic_signal_monitor #(
    parameter int unsigned PERSIST   = 2,
    parameter int unsigned MIN_CLEAR = 500,
    parameter int unsigned MAX_HOLD  = 12000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      vehicle_signal,
    input  logic [7:0]       ped_signal,
    input  logic             fault_clear,
    output logic [3:0]       phase_id,
    output logic             phase_valid,
    output logic [CNT_W-1:0] phase_cycles,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             flash_req
);

    typedef enum logic [1:0] {IDLE = 2'd0, MON = 2'd1, PEND = 2'd2, FLT = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Returns {match, id} for the 16 legal vehicle patterns.
    function automatic logic [4:0] decode_phase(input logic [15:0] veh);
        case (veh)
            16'h8844: return {1'b1, 4'd0};
            16'h4944: return {1'b1, 4'd1};
            16'h9444: return {1'b1, 4'd2};
            16'h1144: return {1'b1, 4'd3};
            16'h4488: return {1'b1, 4'd4};
            16'h4494: return {1'b1, 4'd5};
            16'h4449: return {1'b1, 4'd6};
            16'h4411: return {1'b1, 4'd7};
            16'h2244: return {1'b1, 4'd8};
            16'h8244: return {1'b1, 4'd9};
            16'h4244: return {1'b1, 4'd10};
            16'hA444: return {1'b1, 4'd11};
            16'h4428: return {1'b1, 4'd12};
            16'h4422: return {1'b1, 4'd13};
            16'h44A4: return {1'b1, 4'd14};
            16'h444A: return {1'b1, 4'd15};
            default:  return {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic nibble_bad(input logic [3:0] n);
        return (n == 4'h0) || (n[3] && n[2]) || (n[2] && n[1]) || (n[2] && n[0]);
    endfunction

    function automatic logic veh_go(input logic [3:0] n);
        return n[3] | n[1];
    endfunction

    // A pair of 11 is an illegal lamp, not a walk indication.
    function automatic logic ped_walk(input logic [1:0] p);
        return p == 2'b10;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q, state_d;
    logic [23:0]      bus_q, bus_d;
    logic [3:0]       phase_id_q, phase_id_d;
    logic             phase_valid_q, phase_valid_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0] phase_cycles_q, phase_cycles_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] persist_cnt_q, persist_cnt_d;
    logic             clr_q;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;

    logic [4:0]       dec_s;
    logic [15:0]      veh_s;
    logic [7:0]       ped_s;
    logic             illegal_s, veh_conf_s, ped_conf_s, unknown_s;
    logic [2:0]       static_code_s;
    logic             static_viol_s;
    logic             phase_chg_s, short_s, stuck_s, event_s;
    logic [2:0]       event_code_s;
    logic             clr_rise_s;
    logic [CNT_W-1:0] persist_inc_s;
    logic             static_hit_s;

    assign veh_s = bus_q[15:0];
    assign ped_s = bus_q[23:16];

    // Static checks on the registered bus; lowest code has priority.
    always_comb begin
        illegal_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            illegal_s = illegal_s | nibble_bad(veh_s[4*i +: 4]) | (ped_s[2*i +: 2] == 2'b11);
        end
        veh_conf_s = (veh_go(veh_s[15:12]) | veh_go(veh_s[11:8])) &
                     (veh_go(veh_s[7:4])   | veh_go(veh_s[3:0]));
        ped_conf_s = ((ped_walk(ped_s[7:6]) | ped_walk(ped_s[5:4])) &
                      (veh_go(veh_s[15:12]) | veh_go(veh_s[11:8]))) |
                     ((ped_walk(ped_s[3:2]) | ped_walk(ped_s[1:0])) &
                      (veh_go(veh_s[7:4])   | veh_go(veh_s[3:0])));
        unknown_s  = ~phase_valid_q;
        if (veh_conf_s) begin
            static_code_s = 3'd1;
        end else if (ped_conf_s) begin
            static_code_s = 3'd2;
        end else if (illegal_s) begin
            static_code_s = 3'd3;
        end else if (unknown_s) begin
            static_code_s = 3'd4;
        end else begin
            static_code_s = 3'd0;
        end
        static_viol_s = (static_code_s != 3'd0);
    end

    // Input stage, phase tracking, hold timer and event detection.
    always_comb begin
        bus_d          = {ped_signal, vehicle_signal};
        dec_s          = decode_phase(vehicle_signal);
        phase_valid_d  = dec_s[4];
        phase_id_d     = dec_s[4] ? dec_s[3:0] : phase_id_q;
        phase_chg_s    = (phase_id_d != phase_id_q);
        short_s        = phase_chg_s && phase_id_q[3] && (phase_cnt_q < CNT_W'(MIN_CLEAR));
        phase_cnt_d    = phase_chg_s ? {{(CNT_W-1){1'b0}}, 1'b1} : sat_inc(phase_cnt_q);
        phase_cycles_d = phase_chg_s ? phase_cnt_q : phase_cycles_q;
        hold_cnt_d     = (bus_d != bus_q) ? {CNT_W{1'b0}} : sat_inc(hold_cnt_q);
        stuck_s        = (hold_cnt_d == CNT_W'(MAX_HOLD));
        event_s        = short_s | stuck_s;
        event_code_s   = short_s ? 3'd5 : 3'd6;
        clr_rise_s     = fault_clear & ~clr_q;
        persist_inc_s  = static_viol_s ? sat_inc(persist_cnt_q) : {CNT_W{1'b0}};
        static_hit_s   = static_viol_s && (persist_inc_s == CNT_W'(PERSIST));
    end

    // Monitor FSM: next state, persistence counter and fault latch.
    always_comb begin
        state_d       = state_q;
        persist_cnt_d = {CNT_W{1'b0}};
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        case (state_q)
            IDLE: begin
                fault_d      = 1'b0;
                fault_code_d = 3'd0;
                state_d      = phase_valid_q ? MON : IDLE;
            end
            MON, PEND: begin
                if (static_hit_s) begin
                    state_d      = FLT;
                    fault_d      = 1'b1;
                    fault_code_d = static_code_s;
                end else if (event_s) begin
                    state_d      = FLT;
                    fault_d      = 1'b1;
                    fault_code_d = event_code_s;
                end else if (static_viol_s) begin
                    state_d       = PEND;
                    persist_cnt_d = persist_inc_s;
                end else begin
                    state_d       = MON;
                end
            end
            FLT: begin
                if (clr_rise_s && !static_viol_s && !event_s) begin
                    state_d      = IDLE;
                    fault_d      = 1'b0;
                    fault_code_d = 3'd0;
                end else begin
                    state_d      = FLT;
                end
            end
            default: begin
                state_d      = IDLE;
                fault_d      = 1'b0;
                fault_code_d = 3'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            bus_q          <= 24'h000000;
            phase_id_q     <= 4'd0;
            phase_valid_q  <= 1'b0;
            phase_cnt_q    <= {CNT_W{1'b0}};
            phase_cycles_q <= {CNT_W{1'b0}};
            hold_cnt_q     <= {CNT_W{1'b0}};
            persist_cnt_q  <= {CNT_W{1'b0}};
            clr_q          <= 1'b0;
            fault_q        <= 1'b0;
            fault_code_q   <= 3'd0;
        end else begin
            state_q        <= state_d;
            bus_q          <= bus_d;
            phase_id_q     <= phase_id_d;
            phase_valid_q  <= phase_valid_d;
            phase_cnt_q    <= phase_cnt_d;
            phase_cycles_q <= phase_cycles_d;
            hold_cnt_q     <= hold_cnt_d;
            persist_cnt_q  <= persist_cnt_d;
            clr_q          <= fault_clear;
            fault_q        <= fault_d;
            fault_code_q   <= fault_code_d;
        end
    end

    assign phase_id     = phase_id_q;
    assign phase_valid  = phase_valid_q;
    assign phase_cycles = phase_cycles_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;
    assign flash_req    = fault_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Scoreboard bench for traffic_signal_monitor: directed scenarios plus random bus traffic,
// checked against a rule-level reference model.
module tb_traffic_signal_monitor;

    localparam int PERSIST   = 2;
    localparam int MIN_CLEAR = 500;
    localparam int MAX_HOLD  = 12000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] vehicle_signal = 16'h0000;
    logic [7:0]  ped_signal = 8'h00;
    logic        fault_clear = 1'b0;
    logic [3:0]  phase_id;
    logic        phase_valid;
    logic [15:0] phase_cycles;
    logic        fault;
    logic [2:0]  fault_code;
    logic        flash_req;

    traffic_signal_monitor #(
        .PERSIST(PERSIST), .MIN_CLEAR(MIN_CLEAR), .MAX_HOLD(MAX_HOLD), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .vehicle_signal(vehicle_signal), .ped_signal(ped_signal), .fault_clear(fault_clear),
        .phase_id(phase_id), .phase_valid(phase_valid), .phase_cycles(phase_cycles),
        .fault(fault), .fault_code(fault_code), .flash_req(flash_req)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  id;
        logic        valid;
        logic [15:0] cyc;
        logic        flt;
        logic [2:0]  code;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] pat [16] = '{16'h8844, 16'h4944, 16'h9444, 16'h1144, 16'h4488, 16'h4494,
                              16'h4449, 16'h4411, 16'h2244, 16'h8244, 16'h4244, 16'hA444,
                              16'h4428, 16'h4422, 16'h44A4, 16'h444A};

    // Reference model state, kept in elapsed-time terms.
    int          m_n, m_id_start, m_last_change, m_streak, m_cycles;
    logic [23:0] m_bus;
    logic        m_valid, m_clr_prev, m_armed, m_faulted;
    logic [3:0]  m_id;
    logic [2:0]  m_code;

    function automatic bit head_go(logic [3:0] h);
        return h[3] || h[1];
    endfunction

    function automatic bit head_illegal(logic [3:0] h);
        bit g = h[3], r = h[2], y = h[1], l = h[0];
        return !(g || r || y || l) || (r && (g || y || l));
    endfunction

    function automatic int rule_code(logic [23:0] bus, logic valid);
        logic [15:0] v = bus[15:0];
        logic [7:0]  p = bus[23:16];
        bit sn_go = head_go(v[15:12]) || head_go(v[11:8]);
        bit we_go = head_go(v[7:4]) || head_go(v[3:0]);
        bit sn_walk = (p[7:6] == 2'b10) || (p[5:4] == 2'b10);
        bit we_walk = (p[3:2] == 2'b10) || (p[1:0] == 2'b10);
        bit bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bad = bad || head_illegal(v[4*i +: 4]) || (p[2*i +: 2] == 2'b11);
        end
        if (sn_go && we_go) return 1;
        if ((sn_walk && sn_go) || (we_walk && we_go)) return 2;
        if (bad) return 3;
        if (!valid) return 4;
        return 0;
    endfunction

    function automatic void model_reset();
        m_n = 0; m_id_start = 1; m_last_change = 0; m_streak = 0; m_cycles = 0;
        m_bus = 24'h000000; m_valid = 1'b0; m_clr_prev = 1'b0;
        m_armed = 1'b0; m_faulted = 1'b0; m_id = 4'd0; m_code = 3'd0;
    endfunction

    function automatic void model_step(logic [15:0] veh, logic [7:0] ped, logic clr);
        logic [23:0] nb = {ped, veh};
        int  sc = rule_code(m_bus, m_valid);
        bit  nv = 1'b0;
        int  nid = 0;
        int  dur;
        bit  short_ev, stuck_ev, chg, rise, hit;
        exp_t e;
        m_n++;
        for (int i = 0; i < 16; i++) begin
            if (pat[i] == veh) begin nv = 1'b1; nid = i; end
        end
        chg = nv && (nid != int'(m_id));
        dur = m_n - m_id_start;
        short_ev = chg && (m_id >= 4'd8) && (dur < MIN_CLEAR);
        if (chg) begin
            m_cycles = (dur > 65535) ? 65535 : dur;
            m_id_start = m_n;
            m_id = 4'(nid);
        end
        if (nb != m_bus) m_last_change = m_n;
        stuck_ev = (nb == m_bus) && (m_n - m_last_change == MAX_HOLD);
        rise = clr && !m_clr_prev;
        if (m_faulted) begin
            if (rise && sc == 0 && !short_ev && !stuck_ev) begin
                m_faulted = 1'b0; m_code = 3'd0; m_armed = 1'b0;
            end
        end else if (!m_armed) begin
            m_armed = m_valid;
            m_streak = 0;
        end else begin
            m_streak = (sc != 0) ? m_streak + 1 : 0;
            hit = (sc != 0) && (m_streak == PERSIST);
            if (hit) m_code = 3'(sc);
            else if (short_ev) m_code = 3'd5;
            else if (stuck_ev) m_code = 3'd6;
            if (hit || short_ev || stuck_ev) begin
                m_faulted = 1'b1; m_streak = 0;
            end
        end
        m_bus = nb; m_valid = nv; m_clr_prev = clr;
        e.id = m_id; e.valid = m_valid; e.cyc = 16'(m_cycles); e.flt = m_faulted; e.code = m_code;
        sb_q.push_back(e);
    endfunction

    // Monitor: one expected record per active edge, compared on the following falling edge.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (phase_id !== e.id || phase_valid !== e.valid || phase_cycles !== e.cyc ||
                fault !== e.flt || fault_code !== e.code || flash_req !== e.flt) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got id=%0d v=%0d cyc=%0d f=%0d code=%0d flash=%0d exp id=%0d v=%0d cyc=%0d f=%0d code=%0d",
                         $time, phase_id, phase_valid, phase_cycles, fault, fault_code, flash_req,
                         e.id, e.valid, e.cyc, e.flt, e.code);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Entered and left at falling edge + 1; one expected record per active edge.
    task automatic drive(input logic [15:0] veh, input logic [7:0] ped, input logic clr, input int n);
        for (int i = 0; i < n; i++) begin
            vehicle_signal = veh; ped_signal = ped; fault_clear = clr;
            model_step(veh, ped, clr);
            @(negedge clock); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        check("rst_phase_id", phase_id, 0);
        check("rst_phase_valid", phase_valid, 0);
        check("rst_phase_cycles", phase_cycles, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_code", fault_code, 0);
        check("rst_flash_req", flash_req, 0);
        @(negedge clock); #1;
        vehicle_signal = 16'h0000; ped_signal = 8'h00; fault_clear = 1'b0;
        reset = 1'b1;
    endtask

    task automatic clear_fault(input logic [15:0] veh, input logic [7:0] ped);
        drive(veh, ped, 1'b0, 1);
        drive(veh, ped, 1'b1, 1);
        drive(veh, ped, 1'b0, 2);
    endtask

    initial begin
        logic [15:0] rv;
        logic [7:0]  rp;
        rv = 16'h8844;
        @(negedge clock); #1;
        do_reset();

        // Phase A decodes one cycle after it is applied.
        drive(16'h8844, 8'h5A, 1'b0, 1);
        check("a_phase_id", phase_id, 0);
        check("a_phase_valid", phase_valid, 1);
        check("a_fault", fault, 0);
        drive(16'h8844, 8'h5A, 1'b0, 4);

        // One-cycle conflict glitch is filtered; a held conflict latches code 1.
        drive(16'h8888, 8'h5A, 1'b0, 1);
        drive(16'h8844, 8'h5A, 1'b0, 5);
        check("glitch_fault", fault, 0);
        drive(16'h8888, 8'h5A, 1'b0, 2);
        check("persist_edge_fault", fault, 0);
        drive(16'h8888, 8'h5A, 1'b0, 1);
        check("conflict_fault", fault, 1);
        check("conflict_code", fault_code, 1);
        drive(16'h8844, 8'h5A, 1'b1, 1);
        check("clear_dirty_fault", fault, 1);
        clear_fault(16'h8844, 8'h5A);
        check("clear_ok_fault", fault, 0);
        check("clear_ok_code", fault_code, 0);

        // Short clearance on A1 -> D.
        drive(16'h8844, 8'h5A, 1'b0, 600);
        drive(16'h2244, 8'h5A, 1'b0, 100);
        drive(16'h1144, 8'h5A, 1'b0, 1);
        check("short_clear_code", fault_code, 5);
        clear_fault(16'h1144, 8'h5A);
        drive(16'h8844, 8'h5A, 1'b0, 50);
        drive(16'h2244, 8'h5A, 1'b0, 500);
        drive(16'h1144, 8'h5A, 1'b0, 1);
        check("clear500_fault", fault, 0);
        check("clear500_cycles", phase_cycles, 500);
        drive(16'h8844, 8'h5A, 1'b0, 10);
        drive(16'h2244, 8'h5A, 1'b0, 501);
        drive(16'h1144, 8'h5A, 1'b0, 1);
        check("clear501_fault", fault, 0);
        check("clear501_cycles", phase_cycles, 501);

        // Blinking pedestrian head is legal; a pair of 11 is an illegal lamp.
        for (int i = 0; i < 6; i++) begin
            drive(16'h8844, 8'h5A, 1'b0, 500);
            drive(16'h8844, 8'h52, 1'b0, 500);
        end
        check("ped_blink_fault", fault, 0);
        drive(16'h8844, 8'hFA, 1'b0, 3);
        check("ped_illegal_code", fault_code, 3);
        clear_fault(16'h8844, 8'h5A);

        // Stuck bus.
        drive(16'h4411, 8'hA5, 1'b0, 12000);
        drive(16'h8844, 8'h5A, 1'b0, 1);
        check("hold_then_change_fault", fault, 0);
        drive(16'h4411, 8'hA5, 1'b0, 12000);
        check("hold_below_fault", fault, 0);
        drive(16'h4411, 8'hA5, 1'b0, 1);
        check("stuck_code", fault_code, 6);

        // Clear is ignored while the bus violates, honoured once it is legal.
        drive(16'h8888, 8'h5A, 1'b0, 1);
        drive(16'h8888, 8'h5A, 1'b1, 1);
        check("clear_ignored_fault", fault, 1);
        check("clear_ignored_code", fault_code, 6);
        clear_fault(16'h8844, 8'h5A);
        check("clear_legal_fault", fault, 0);
        drive(16'h8844, 8'h5A, 1'b0, 3);

        // Reset while pending.
        drive(16'h8888, 8'h5A, 1'b0, 2);
        check("pend_fault", fault, 0);
        do_reset();

        // Random traffic: legal phases, corrupt buses, random pedestrian heads and clears.
        for (int s = 0; s < 250; s++) begin
            int r = $urandom_range(0, 9);
            if (r < 6) rv = pat[$urandom_range(0, 15)];
            else if (r < 8) rv = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rp = 8'h55;
                1:       rp = 8'h5A;
                2:       rp = 8'hA5;
                default: rp = 8'($urandom);
            endcase
            drive(rv, rp, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom_range(1, 40));
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
